// File: rtl/xbtn_debounce.sv
// Push-button conditioner: two-flop synchroniser, per-button debounce FSM and sticky press-event latch.
// Optional macro BTN_AUTOREPEAT_EN re-sets the event bit every REPEAT_CYCLES while a button stays held.
//
// state       | meaning
// ------------+--------------------------------------------------
// IDLE        | button released and stable
// DEB_PRESS   | synchronised input high, counting towards accept
// PRESSED     | button accepted as held, btn_level = 1
// DEB_RELEASE | synchronised input low, counting towards release
module xbtn_debounce #(
   parameter int N_BTN         = 4,
   parameter int DB_CYCLES     = 1000000,
   parameter int CNT_W         = 20,
   parameter int REPEAT_CYCLES = 25000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_in,
   input  logic             rd_clr,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_event
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DEB_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      DEB_RELEASE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [N_BTN-1:0] s1_q;
   logic [N_BTN-1:0] s2_q;
   logic [N_BTN-1:0] set_d;
   logic [N_BTN-1:0] event_d;
   logic [N_BTN-1:0] event_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= btn_in;
         s2_q <= s1_q;
      end
   end

   for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      state_t           state_q;
      logic [CNT_W-1:0] cnt_q;
      logic             level_q;
      logic             hit_press;

      assign hit_press = (state_q == DEB_PRESS) && s2_q[gi] && (cnt_q == CNT_LAST);

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (s2_q[gi]) begin
                     state_q <= DEB_PRESS;
                     cnt_q   <= '0;
                  end
               end
               DEB_PRESS: begin
                  if (!s2_q[gi]) begin
                     state_q <= IDLE;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q <= PRESSED;
                     level_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               PRESSED: begin
                  if (!s2_q[gi]) begin
                     state_q <= DEB_RELEASE;
                     cnt_q   <= '0;
                  end
               end
               DEB_RELEASE: begin
                  // a short low glitch returns straight to PRESSED without a new event
                  if (s2_q[gi]) begin
                     state_q <= PRESSED;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q <= IDLE;
                     level_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  level_q <= 1'b0;
               end
            endcase
         end
      end

      assign btn_level[gi] = level_q;

`ifdef BTN_AUTOREPEAT_EN
      localparam int REP_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
      localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

      logic [REP_W-1:0] rep_q;
      logic             hit_rep;

      // counter only advances while the button stays settled in PRESSED
      assign hit_rep = (state_q == PRESSED) && s2_q[gi] && (rep_q == REP_LAST);

      always_ff @(posedge clk) begin
         if (rst) begin
            rep_q <= '0;
         end else if ((state_q == PRESSED) && s2_q[gi]) begin
            rep_q <= hit_rep ? '0 : rep_q + REP_W'(1);
         end else begin
            rep_q <= '0;
         end
      end

      assign set_d[gi] = hit_press | hit_rep;
`else
      assign set_d[gi] = hit_press;
`endif
   end

   // a bit being set wins over a simultaneous read-clear
   assign event_d = set_d | (event_q & ~{N_BTN{rd_clr}});

   always_ff @(posedge clk) begin
      if (rst) begin
         event_q <= '0;
      end else begin
         event_q <= event_d;
      end
   end

   assign btn_event = event_q;

endmodule

// File: tb/tb_xbtn_debounce.sv
// Randomised self-checking bench for xbtn_debounce against a run-length behavioural model.
// Define BTN_AUTOREPEAT_EN for both bench and RTL to exercise the auto-repeat build.
module tb_xbtn_debounce;
   localparam int N   = 4;
   localparam int DB  = 8;
   localparam int RPT = 20;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] btn_in = '0;
   logic         rd_clr = 1'b0;
   logic [N-1:0] btn_level;
   logic [N-1:0] btn_event;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   xbtn_debounce #(
      .N_BTN(N), .DB_CYCLES(DB), .CNT_W(4), .REPEAT_CYCLES(RPT)
   ) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in), .rd_clr(rd_clr),
      .btn_level(btn_level), .btn_event(btn_event)
   );

   always #5 clk = ~clk;

   // Model: the level flips once the synchronised input has disagreed with it
   // for DB+1 consecutive edges; events on rising level, plus every RPT edges
   // of settled holding in the auto-repeat build.
   logic [N-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_evt = '0;
   int run [N];
   int hold [N];

   always @(posedge clk) begin : model
      logic [N-1:0] set_v;
      int           run_old;
      set_v = '0;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0; m_evt = '0;
         for (int i = 0; i < N; i++) begin run[i] = 0; hold[i] = 0; end
      end else begin
         for (int i = 0; i < N; i++) begin
            run_old = run[i];
            if (m_s2[i] != m_lvl[i]) run[i] = run[i] + 1;
            else run[i] = 0;
`ifdef BTN_AUTOREPEAT_EN
            if (m_lvl[i] && m_s2[i] && run_old == 0) begin
               hold[i] = hold[i] + 1;
               if (hold[i] % RPT == 0) set_v[i] = 1'b1;
            end else begin
               hold[i] = 0;
            end
`else
            hold[i] = run_old;
`endif
            if (run[i] == DB + 1) begin
               m_lvl[i] = ~m_lvl[i];
               run[i]   = 0;
               hold[i]  = 0;
               if (m_lvl[i]) set_v[i] = 1'b1;
            end
         end
         m_evt = (rd_clr ? '0 : m_evt) | set_v;
         m_s2  = m_s1;
         m_s1  = btn_in;
      end
   end

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_level", btn_level, m_lvl);
         chk("model_event", btn_event, m_evt);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_clr();
      rd_clr = 1'b1;
      step(1);
      rd_clr = 1'b0;
   endtask

   initial begin
      // 1: reset, idle
      step(2);
      rst = 1'b0;
      chk_en = 1'b1;
      step(20);
      chk("idle_level", btn_level, 4'b0000);
      chk("idle_event", btn_event, 4'b0000);

      // 2: clean press latency and clear
      btn_in[0] = 1'b1;
      step(10);
      chk("press_early", btn_level, 4'b0000);
      chk("press_early_ev", btn_event, 4'b0000);
      step(1);
      chk("press_level", btn_level, 4'b0001);
      chk("press_event", btn_event, 4'b0001);
      pulse_clr();
      chk("clr_event", btn_event, 4'b0000);
      chk("clr_level", btn_level, 4'b0001);

      // 4: short release glitch, then real release
      btn_in[0] = 1'b0;
      step(3);
      btn_in[0] = 1'b1;
      step(15);
      chk("glitch_level", {3'b0, btn_level[0]}, 4'b0001);
`ifndef BTN_AUTOREPEAT_EN
      chk("glitch_event", btn_event, 4'b0000);
`endif
      btn_in[0] = 1'b0;
      step(10);
      chk("release_early", {3'b0, btn_level[0]}, 4'b0001);
      step(1);
      chk("release_level", btn_level, 4'b0000);

      // 3: bouncing press on button 1
      pulse_clr();
      foreach (btn_in[j]) if (j == 1) btn_in[j] = 1'b1;
      step(1); btn_in[1] = 1'b0; step(1); btn_in[1] = 1'b1; step(1);
      btn_in[1] = 1'b0; step(1); btn_in[1] = 1'b1; step(1);
      step(9);
      chk("bounce_early", btn_level, 4'b0000);
      step(1);
      chk("bounce_level", btn_level, 4'b0010);
      chk("bounce_event", {3'b0, btn_event[1]}, 4'b0001);
      pulse_clr();
      step(5);
      chk("bounce_single", {3'b0, btn_event[1]}, 4'b0000);

      // 5: clear coincident with set, then separate clear
      btn_in[2] = 1'b1;
      step(10);
      rd_clr = 1'b1;
      step(1);
      rd_clr = 1'b0;
      chk("set_wins", {3'b0, btn_event[2]}, 4'b0001);
      pulse_clr();
      chk("later_clr", {3'b0, btn_event[2]}, 4'b0000);

      // 6: held button, repeat or not
      btn_in[3] = 1'b1;
      step(11);
      chk("hold_first", {3'b0, btn_event[3]}, 4'b0001);
      pulse_clr();
`ifdef BTN_AUTOREPEAT_EN
      step(18);
      chk("repeat_early", {3'b0, btn_event[3]}, 4'b0000);
      step(1);
      chk("repeat_event", {3'b0, btn_event[3]}, 4'b0001);
`else
      step(40);
      chk("no_repeat", {3'b0, btn_event[3]}, 4'b0000);
`endif

      // reset with outputs active, then buttons held through reset release
      btn_in[0] = 1'b1;
      step(11);
      chk("pre_rst_level", btn_level, 4'b1111);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("rst_level", btn_level, 4'b0000);
      chk("rst_event", btn_event, 4'b0000);
      step(10);
      chk("held_rst_early", btn_level, 4'b0000);
      step(1);
      chk("held_rst_level", btn_level, 4'b1111);
      chk("held_rst_event", btn_event, 4'b1111);

      // random phase, checked every cycle by the model comparison
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 11) == 0) btn_in[b] = ~btn_in[b];
         rd_clr = ($urandom_range(0, 7) == 0);
         rst    = ($urandom_range(0, 399) == 0);
         step(1);
      end
      rst = 1'b0;
      rd_clr = 1'b0;
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
